// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for a downstream bit-serial FSM: one bit per clock on x, first bit the cycle after accept.
// din_ready is a decode of registered state only; back-to-back words are possible only when GAP is zero.
module serial_bit_feeder #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter int   GAP       = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic                       x,
  output logic                       busy,
  output logic [$clog2(WIDTH)-1:0]   bit_idx,
  output logic                       word_done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [IW-1:0] PRE_IDX  = IW'(WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [7:0]       gap_cnt;
  logic             last;
  logic             accept;
  logic             din_first;
  logic [WIDTH-1:0] din_rest;
  logic             sreg_first;
  logic [WIDTH-1:0] sreg_rest;

  assign last      = (state == S_SHIFT) && (bit_idx == LAST_IDX);
  assign din_ready = (state == S_IDLE) || (last && (GAP == 0));
  assign accept    = din_valid && din_ready;

  // The first bit goes straight to x on load, so sreg only holds the bits still to come.
  assign din_first  = (MSB_FIRST != 0) ? din[WIDTH-1]  : din[0];
  assign din_rest   = (MSB_FIRST != 0) ? (din << 1)    : (din >> 1);
  assign sreg_first = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
  assign sreg_rest  = (MSB_FIRST != 0) ? (sreg << 1)   : (sreg >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sreg      <= '0;
      gap_cnt   <= '0;
      x         <= IDLE_BIT;
      busy      <= 1'b0;
      bit_idx   <= '0;
      word_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_SHIFT;
            x         <= din_first;
            sreg      <= din_rest;
            busy      <= 1'b1;
            bit_idx   <= '0;
            word_done <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (!last) begin
            x         <= sreg_first;
            sreg      <= sreg_rest;
            bit_idx   <= bit_idx + 1'b1;
            word_done <= (bit_idx == PRE_IDX);
          end else begin
            word_done <= 1'b0;
            bit_idx   <= '0;
            if (GAP > 0) begin
              state   <= S_GAP;
              x       <= IDLE_BIT;
              gap_cnt <= 8'(GAP - 1);
            end else if (accept) begin
              x       <= din_first;
              sreg    <= din_rest;
            end else begin
              state   <= S_IDLE;
              x       <= IDLE_BIT;
              busy    <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          x     <= IDLE_BIT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial stage that sits directly upstream of the team's 3-bit serial state machine and drives its single-bit `x` input. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, MSB- or LSB-first. It inserts a programmable idle gap between words and holds a defined idle level on `x` whenever no word is in flight. The downstream FSM samples `x` every rising edge and has no valid qualifier, so every cycle of `x` is meaningful.

## Interface

Parameters:
- `WIDTH`, 8: bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- `GAP`, 1: idle cycles inserted after each word; legal range 0..255.
- `IDLE_BIT`, 0: level driven on `x` when not shifting (idle, gap, reset).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock, shared with the downstream FSM.
- `rst`  in  1  synchronous active-high reset.
- `din`  in  WIDTH  parallel word, captured on an accepted handshake.
- `din_valid`  in  1  upstream word available.
- `din_ready`  out  1  block can accept `din` this cycle.
- `x`  out  1  serial bit to the downstream FSM; registered.
- `busy`  out  1  high in SHIFT or GAP.
- `bit_idx`  out  $clog2(WIDTH)  transfer-order index of the bit currently on `x`; 0 outside SHIFT.
- `word_done`  out  1  one-cycle pulse while the last bit of a word is on `x`.

## Operation

- States: IDLE, SHIFT, GAP. Shift register WIDTH bits, bit counter, gap counter 8 bits.
- Accept: `din_valid & din_ready` sampled high at a rising edge.
- `din_ready` = (state==IDLE) | (state==SHIFT & last bit on `x` & GAP==0). It is a combinational decode of registered state only and never depends on `din_valid`.
- IDLE: `x`=IDLE_BIT. On accept, capture `din`, drive the first transfer-order bit onto `x`, set bit_idx=0, go to SHIFT.
- SHIFT: each edge advances to the next bit and increments bit_idx. When bit_idx==WIDTH-1 (last bit on `x`), `word_done`=1. On the following edge:
  - GAP>0: go to GAP, `x`=IDLE_BIT, gap counter=GAP-1.
  - GAP==0 and accept: load the new word and drive its first bit (no idle cycle).
  - GAP==0 and no accept: go to IDLE, `x`=IDLE_BIT.
- GAP: `x`=IDLE_BIT. When the gap counter reaches 0, go to IDLE on the next edge; otherwise decrement.
- `din` and `din_valid` are ignored while not ready. A changing `din` never corrupts a word in flight.
- Reset (any state, including mid-word): state=IDLE, `x`=IDLE_BIT, `busy`=0, `word_done`=0, `bit_idx`=0, shift register=0. The in-flight word is discarded, with no `word_done`.
- `rst` has priority over a simultaneous accept.

## Timing

- Reset values: `x`=IDLE_BIT, `din_ready`=1, `busy`=0, `bit_idx`=0, `word_done`=0.
- Latency: accept at edge N puts the first bit on `x` in cycle N+1, directly after that edge.
- Each bit is held exactly one cycle; a word occupies cycles N+1..N+WIDTH. `word_done` is high in cycle N+WIDTH.
- GAP>0: `x`=IDLE_BIT for cycles N+WIDTH+1..N+WIDTH+GAP; `din_ready` rises in cycle N+WIDTH+GAP+1. Word period = WIDTH+GAP+1 cycles minimum.
- GAP==0 with `din_valid` held: a continuous stream, one word every WIDTH cycles, with no idle bit between words.
- All outputs except `din_ready` are registered.

## Test plan

- Reset: hold `rst` 2 cycles while `din_valid`=1 -> `x`=0, `busy`=0, `din_ready`=1, no word accepted.
- WIDTH=8, MSB_FIRST=1, GAP=1, `din`=8'hB2 accepted at edge N:
  - `x` = 1,0,1,1,0,0,1,0 on cycles N+1..N+8, `bit_idx` 0..7.
  - `word_done` high only in cycle N+8.
  - Cycle N+9: `x`=0, `busy`=1, `din_ready`=0.
  - Cycle N+10: `din_ready`=1, `busy`=0.
- MSB_FIRST=0, `din`=8'hB2 -> `x` = 0,1,0,0,1,1,0,1; `word_done` in the 8th cycle.
- GAP=0, `din_valid` held with 8'hFF then 8'h00:
  - 16 contiguous `x` cycles (eight 1s, then eight 0s).
  - `din_ready`=1 in the 8th cycle.
  - `word_done` pulses at cycles 8 and 16.
  - No idle cycle between words.
- Reset mid-word: assert `rst` after 3 bits of 8'hFF -> next cycle `x`=IDLE_BIT, `din_ready`=1, no `word_done`. A following 8'hA5 is sent intact: 1,0,1,0,0,1,0,1.
- While busy, pulse `din_valid` with `din`=8'h00 and change `din` each cycle -> the current word completes unchanged and the pulsed word is not sent.
